ysyx_22041071_div: RTL and testbench
====================================

# ysyx_22041071_div

Iterative radix-2 restoring integer divider for the RV64M execute stage, alongside the single-cycle multiplier. Covers DIV/DIVU/REM/REMU and the 32-bit W forms in one unit. A request is accepted through a valid/ready handshake. The block returns quotient and remainder together after a data-dependent, fixed-per-width latency. It supports pipeline flush at any point.

## Interface
Parameters: none.

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  cancel in-flight or offered division (synchronous)
- div_valid  input  1  high: operands valid, request offered
- divw  input  1  1 = 32-bit operation on bits [31:0], result sign-extended
- div_signed  input  1  1 = signed (DIV/REM), 0 = unsigned
- dividend  input  64  dividend
- divisor  input  64  divisor
- div_ready  output  1  high: divider idle, can accept request
- out_valid  output  1  one-cycle pulse: quotient/remainder valid
- quotient  output  64  quotient
- remainder  output  64  remainder

One clock, `clk`. Reset `rst_n` is asynchronous and active-low.

## Operation
- States: IDLE, CALC, DONE.
- Reset values:
  - state = IDLE.
  - div_ready = 1.
  - out_valid = 0.
  - quotient = 0.
  - remainder = 0.
  - All internal registers = 0.
- Acceptance occurs at a rising edge where state == IDLE, div_valid = 1 and flush = 0.
  - Operands are latched at that edge.
  - Caller may change the operands afterwards.
- Operand prep, width W = 32 if divw else 64:
  - Take the low W bits of each operand.
  - If div_signed, record both signs and convert each operand to its magnitude.
  - Otherwise treat the operands as unsigned.
- Special cases are resolved at acceptance and go straight to DONE:
  - Divisor (low W bits) == 0: quotient = all ones (W bits), remainder = dividend (W bits).
  - Signed overflow, i.e. dividend = -2^(W-1) and divisor = -1: quotient = dividend, remainder = 0.
- Normal path, CALC:
  - One iteration per cycle, W iterations.
  - Each iteration: shift partial remainder (W+1 bits) left by one, bringing in the next dividend bit MSB-first.
  - Trial-subtract the divisor magnitude.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - An iteration counter runs from 0 to W-1. The last iteration moves the state to DONE.
- Sign fix, applied when entering DONE and only if div_signed:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- Output width:
  - If divw, both results are sign-extended from bit 31. This also applies to unsigned W ops (DIVUW/REMUW).
  - Otherwise results are the full 64 bits.
- Result registers hold their value until the next DONE.
- DONE lasts one cycle, then returns to IDLE.
- Flush:
  - With flush = 1 at an edge, state goes to IDLE regardless of current state, and the operation is discarded.
  - out_valid is masked combinationally by flush: out_valid = (state == DONE) & ~flush.
  - quotient and remainder are not updated by a flushed operation.
- rst_n low mid-operation: immediate return to reset values, with no out_valid.

## Timing
- div_ready = (state == IDLE). It is a registered state decode, with no combinational path from div_valid.
- Acceptance edge = E0.
- Normal 64-bit: CALC from E0 to E64, DONE from E64 to E65. out_valid high for exactly the cycle after E64. div_ready goes high again at E65.
- Normal divw: out_valid in the cycle after E32. div_ready goes high at E33.
- Special cases: out_valid in the cycle after E0. div_ready goes high at E1.
- No request is accepted in CALC or DONE. The earliest back-to-back acceptance is E65 (or E33 / E1).
- div_valid and flush both high in IDLE: no acceptance, and state remains IDLE.

## Test plan
- Unsigned 64-bit, dividend = 100, divisor = 7, div_signed = 0. Required response:
  - out_valid pulses exactly once, in the cycle after E64.
  - quotient = 14, remainder = 2.
  - div_ready is low in cycles E1..E64.
- Signed 64-bit, dividend = -7, divisor = 2. Required response:
  - quotient = 0xFFFF_FFFF_FFFF_FFFE (-3).
  - remainder = 0xFFFF_FFFF_FFFF_FFFF (-1).
- divw signed, dividend = 0x8000_0000, divisor = 0xFFFF_FFFF. Required response:
  - out_valid in the cycle after E0.
  - quotient = 0xFFFF_FFFF_8000_0000, remainder = 0.
- divw unsigned, dividend = 0xFFFF_FFFF, divisor = 1. Required response:
  - out_valid after E32.
  - quotient = 0xFFFF_FFFF_FFFF_FFFF (sign-extended), remainder = 0.
- Divide by zero, 64-bit signed, dividend = 5, divisor = 0. Required response:
  - out_valid after E0.
  - quotient = 0xFFFF_FFFF_FFFF_FFFF, remainder = 5.
- Flush and reset interruptions:
  - Stimulus: start 64-bit 1000/3, assert flush at E10. Response: no out_valid, div_ready high after E11, and quotient/remainder keep their prior values. Then 9/3 returns quotient = 3, remainder = 0 after 64 iterations.
  - Stimulus: repeat the 1000/3 request and drop rst_n at E20. Response: all outputs are at their reset values immediately.

Source files
------------

// File: rtl/ysyx_22041071_div.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and W forms.
// Quotient and remainder are produced together; W iterations per normal divide,
// divide-by-zero and signed overflow resolve in a single cycle.
//
// state | meaning
// IDLE  | waiting for a request, div_ready high
// CALC  | one restoring iteration per cycle
// DONE  | results valid for one cycle (out_valid unless flushed)
module ysyx_22041071_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        div_valid,
    input  logic        divw,
    input  logic        div_signed,
    input  logic [63:0] dividend,
    input  logic [63:0] divisor,
    output logic        div_ready,
    output logic        out_valid,
    output logic [63:0] quotient,
    output logic [63:0] remainder
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t      state, state_nxt;

    logic [63:0] dvd_r;      // dividend bits shift out of the top, quotient bits shift in below
    logic [63:0] dvs_r;      // divisor magnitude
    logic [63:0] rem_r;      // partial remainder
    logic [5:0]  cnt;
    logic        is_w, is_signed, sign_a, sign_b;

    logic        accept;
    logic [63:0] a_w, b_w, a_abs, b_abs, a_mag, b_mag;
    logic [63:0] min_w, ones_w;
    logic        a_neg, b_neg, div_zero, ovf, special;

    logic [64:0] shifted, diff;
    logic        qbit, last;
    logic [63:0] rem_nxt, dvd_nxt, q_raw, r_raw, q_fix, r_fix;

    function automatic logic [63:0] sext32(input logic [63:0] x);
        return {{32{x[31]}}, x[31:0]};
    endfunction

    assign accept    = (state == S_IDLE) & div_valid & ~flush;
    assign div_ready = (state == S_IDLE);
    assign out_valid = (state == S_DONE) & ~flush;

    // Operand preparation: select width, detect signs, take magnitudes and special cases
    always_comb begin
        a_w     = divw ? {32'b0, dividend[31:0]} : dividend;
        b_w     = divw ? {32'b0, divisor[31:0]}  : divisor;
        min_w   = divw ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
        ones_w  = divw ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        a_neg   = div_signed & (divw ? dividend[31] : dividend[63]);
        b_neg   = div_signed & (divw ? divisor[31]  : divisor[63]);
        a_abs   = a_neg ? (64'd0 - a_w) : a_w;
        b_abs   = b_neg ? (64'd0 - b_w) : b_w;
        a_mag   = divw ? {32'b0, a_abs[31:0]} : a_abs;
        b_mag   = divw ? {32'b0, b_abs[31:0]} : b_abs;
        div_zero = (b_w == 64'd0);
        ovf     = div_signed & (a_w == min_w) & (b_w == ones_w);
        special = div_zero | ovf;
    end

    // One restoring step plus sign fix and width adjustment of the final result
    always_comb begin
        shifted = {rem_r, dvd_r[63]};
        diff    = shifted - {1'b0, dvs_r};
        qbit    = ~diff[64];
        rem_nxt = qbit ? diff[63:0] : shifted[63:0];
        dvd_nxt = {dvd_r[62:0], qbit};
        last    = (cnt == (is_w ? 6'd31 : 6'd63));
        q_raw   = is_w ? {32'b0, dvd_nxt[31:0]} : dvd_nxt;
        r_raw   = rem_nxt;
        q_fix   = (is_signed & (sign_a ^ sign_b)) ? (64'd0 - q_raw) : q_raw;
        r_fix   = (is_signed & sign_a) ? (64'd0 - r_raw) : r_raw;
        if (is_w) begin
            q_fix = sext32(q_fix);
            r_fix = sext32(r_fix);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; flush returns to IDLE from anywhere
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = special ? S_DONE : S_CALC;
            S_CALC:  if (last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush) state_nxt = S_IDLE;
    end

    // Datapath: latch operands on accept, iterate in CALC, publish results entering DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_r     <= '0;
            dvs_r     <= '0;
            rem_r     <= '0;
            cnt       <= '0;
            is_w      <= 1'b0;
            is_signed <= 1'b0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (accept) begin
            dvd_r     <= divw ? {a_mag[31:0], 32'b0} : a_mag;
            dvs_r     <= b_mag;
            rem_r     <= '0;
            cnt       <= '0;
            is_w      <= divw;
            is_signed <= div_signed;
            sign_a    <= a_neg;
            sign_b    <= b_neg;
            if (div_zero) begin
                quotient  <= divw ? sext32(ones_w) : ones_w;
                remainder <= divw ? sext32(a_w) : a_w;
            end else if (ovf) begin
                quotient  <= divw ? sext32(a_w) : a_w;
                remainder <= '0;
            end
        end else if (state == S_CALC && !flush) begin
            dvd_r <= dvd_nxt;
            rem_r <= rem_nxt;
            cnt   <= cnt + 6'd1;
            if (last) begin
                quotient  <= q_fix;
                remainder <= r_fix;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22041071_div.sv
// Scoreboard bench for the RV64M divider: requests push expected results,
// a negedge monitor pops and compares on every out_valid.
module tb_ysyx_22041071_div;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        div_valid = 1'b0;
    logic        divw = 1'b0;
    logic        div_signed = 1'b0;
    logic [63:0] dividend = '0;
    logic [63:0] divisor = '0;
    logic        div_ready, out_valid;
    logic [63:0] quotient, remainder;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [63:0] last_q = '0;
    logic [63:0] last_r = '0;

    ysyx_22041071_div dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .div_valid(div_valid),
        .divw(divw), .div_signed(div_signed), .dividend(dividend), .divisor(divisor),
        .div_ready(div_ready), .out_valid(out_valid),
        .quotient(quotient), .remainder(remainder)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: RISC-V M semantics with plain arithmetic
    function automatic void ref_div(input logic [63:0] a, input logic [63:0] b,
                                    input bit w, input bit s,
                                    output logic [63:0] q, output logic [63:0] r,
                                    output bit sp);
        logic [31:0] a32, b32, q32, r32;
        int          sa, sd;
        longint      la, lb;
        sp = 0;
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 32'd0) begin
                q32 = 32'hFFFF_FFFF; r32 = a32; sp = 1;
            end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32; r32 = 32'd0; sp = 1;
            end else if (s) begin
                sa = a32; sd = b32;
                q32 = sa / sd; r32 = sa % sd;
            end else begin
                q32 = a32 / b32; r32 = a32 % b32;
            end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else begin
            if (b == 64'd0) begin
                q = 64'hFFFF_FFFF_FFFF_FFFF; r = a; sp = 1;
            end else if (s && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
                q = a; r = 64'd0; sp = 1;
            end else if (s) begin
                la = a; lb = b;
                q = la / lb; r = la % lb;
            end else begin
                q = a / b; r = a % b;
            end
        end
    endfunction

    // Monitor: ready must track "nothing in flight", every out_valid pops one expectation
    always @(negedge clk) begin
        if (rst_n) begin
            chk("div_ready", {63'b0, div_ready}, {63'b0, sb.size() == 0});
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_out_valid: got 1 expected 0 (t=%0t)", $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("quotient", quotient, e.q);
                    chk("remainder", remainder, e.r);
                    chk("latency_cycle", 64'(cyc), 64'(e.cyc));
                    last_q = e.q;
                    last_r = e.r;
                end
            end
        end
    end

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input bit w, input bit s);
        exp_t e;
        bit   sp;
        int   t = 0;
        @(negedge clk);
        while (!div_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            n_tests++; n_fail++;
            $display("FAIL ready_timeout: got 0 expected 1");
        end
        dividend = a; divisor = b; divw = w; div_signed = s; div_valid = 1'b1;
        ref_div(a, b, w, s, e.q, e.r, sp);
        @(posedge clk);
        #1;
        e.cyc = cyc + (sp ? 0 : (w ? 32 : 64));
        sb.push_back(e);
        div_valid = 1'b0;
        dividend = {$urandom, $urandom};
        divisor = {$urandom, $urandom};
    endtask

    task automatic wait_idle();
        int t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            n_tests++; n_fail++;
            $display("FAIL drain_timeout: got %0d expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a, b;
        bit          w, s;
        int          mode;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", {63'b0, div_ready}, 64'd1);
        chk("reset_out_valid", {63'b0, out_valid}, 64'd0);
        chk("reset_quotient", quotient, 64'd0);
        chk("reset_remainder", remainder, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(64'd100, 64'd7, 1'b0, 1'b0);
        wait_idle();
        issue(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 1'b1);
        wait_idle();
        issue(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1);
        wait_idle();
        issue(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b1, 1'b0);
        wait_idle();
        issue(64'd5, 64'd0, 1'b0, 1'b1);
        wait_idle();
        issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        wait_idle();

        // Request offered together with flush while idle must be ignored
        @(negedge clk);
        dividend = 64'd50; divisor = 64'd5; divw = 1'b0; div_signed = 1'b0;
        div_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        div_valid = 1'b0; flush = 1'b0;
        repeat (3) @(negedge clk);

        // Flush mid-calculation: no result, outputs hold previous values
        issue(64'd1000, 64'd3, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        flush = 1'b0;
        repeat (70) @(negedge clk);
        chk("flush_hold_quotient", quotient, last_q);
        chk("flush_hold_remainder", remainder, last_r);
        issue(64'd9, 64'd3, 1'b0, 1'b0);
        wait_idle();

        // Asynchronous reset mid-calculation
        issue(64'd1000, 64'd3, 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("rst_mid_ready", {63'b0, div_ready}, 64'd1);
        chk("rst_mid_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_mid_quotient", quotient, 64'd0);
        chk("rst_mid_remainder", remainder, 64'd0);
        last_q = '0;
        last_r = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized mix, back-to-back where the divider allows
        for (int i = 0; i < 60; i++) begin
            w = 1'($urandom % 2);
            s = 1'($urandom % 2);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            mode = int'($urandom % 8);
            case (mode)
                0: b = w ? {b[63:32], 32'd0} : 64'd0;
                1: b = 64'($urandom % 16);
                2: begin
                    a = w ? {a[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000;
                    b = w ? {b[63:32], 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
                end
                3: b = b >> ($urandom % 64);
                4: a = a >> ($urandom % 64);
                default: ;
            endcase
            issue(a, b, w, s);
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
